// File: rtl/psum_accum_if.sv
// psum_accum_if -- control, issue and result handshake bundle for psum_accum.
//   start/len/ngroups : job launch (pulse + job geometry)
//   in_valid/in_ready : issue handshake toward the MAC tile
//   psum              : MAC tile output, valid two edges after an accepted issue
//   out_*             : result FIFO head with valid/ready pop handshake
//   busy/done         : job status
// The master side is the job controller / consumer; slave is psum_accum.
interface psum_accum_if #(
  parameter int bw_psum = 19,
  parameter int bw_acc  = 23
);
  logic               start;
  logic [3:0]         len;
  logic [7:0]         ngroups;
  logic               in_valid;
  logic               in_ready;
  logic [bw_psum-1:0] psum;
  logic [bw_acc-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport master (
    output start, len, ngroups, in_valid, psum, out_ready,
    input  in_ready, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, len, ngroups, in_valid, psum, out_ready,
    output in_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/psum_accum.sv
// psum_accum -- accumulates groups of len partial sums from a MAC tile and
// queues one result per group in a small FIFO.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : psum_accum_if.slave (start/len/ngroups, issue handshake, psum,
//           result FIFO head + pop handshake, busy/done)
// Issues are throttled so that every result already in flight has a FIFO
// slot reserved; the FIFO therefore never overflows.
module psum_accum #(
  parameter int bw_psum    = 19,
  parameter int bw_acc     = 23,
  parameter int fifo_depth = 4
) (
  input  logic        clk,
  input  logic        reset,
  psum_accum_if.slave bus
);
  localparam int pw = $clog2(fifo_depth);
  localparam int cw = pw + 1;
  localparam int ow = cw + 1;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t state, state_nx;

  logic [3:0]  len_q;
  logic [7:0]  ngroups_q;
  logic [11:0] issue_cnt;
  logic [3:0]  pos_cnt;

  // vld_pipe[1]/[2] are the v1/v2 stages; lst_pipe carries last-of-group.
  logic [2:1] vld_pipe, lst_pipe;

  logic                     acc_fresh;
  logic signed [bw_acc-1:0] acc;
  logic signed [bw_acc-1:0] psum_ext, acc_sum;

  logic [bw_acc-1:0] mem [fifo_depth];
  logic [pw-1:0]     wr_ptr, rd_ptr;
  logic [cw-1:0]     fifo_count;

  logic        fire, is_last, job_end, start_ok, push, pop;
  logic [11:0] job_total;
  logic [1:0]  pending;
  logic [ow-1:0] occ;
  logic        busy_c, done_c;

  assign start_ok  = bus.start && (bus.len != 4'd0) && (bus.ngroups != 8'd0);
  assign fire      = bus.in_valid && bus.in_ready;
  assign is_last   = (pos_cnt == len_q - 4'd1);
  assign job_total = 12'(len_q) * 12'(ngroups_q);
  assign job_end   = fire && (issue_cnt == job_total - 12'd1);

  // Results still in the pipe already own a FIFO slot.
  assign pending = {1'b0, vld_pipe[1] & lst_pipe[1]} + {1'b0, vld_pipe[2] & lst_pipe[2]};
  assign occ     = {1'b0, fifo_count} + ow'(pending);
  assign bus.in_ready = (state == ACC) && (occ < ow'(fifo_depth));

  assign psum_ext = {{(bw_acc-bw_psum){bus.psum[bw_psum-1]}}, bus.psum};
  // First psum of a group overwrites acc, so no clear cycle is needed.
  assign acc_sum  = acc_fresh ? psum_ext : acc + psum_ext;
  assign push     = vld_pipe[2] & lst_pipe[2];
  assign pop      = bus.out_valid && bus.out_ready;

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = (state != IDLE);
    done_c   = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nx = ACC;
      ACC:   if (job_end)  state_nx = DRAIN;
      DRAIN: if ((vld_pipe == 2'b00) && (fifo_count == '0)) begin
               state_nx = IDLE;
               done_c   = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
  end

  // Issue side: group position is decided here, at issue time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      ngroups_q <= '0;
      issue_cnt <= '0;
      pos_cnt   <= '0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
    end else begin
      if (state == IDLE && start_ok) begin
        len_q     <= bus.len;
        ngroups_q <= bus.ngroups;
        issue_cnt <= '0;
        pos_cnt   <= '0;
      end
      if (fire) begin
        issue_cnt <= job_end ? 12'd0 : issue_cnt + 12'd1;
        pos_cnt   <= is_last ? 4'd0  : pos_cnt + 4'd1;
      end
      vld_pipe[1] <= fire;
      lst_pipe[1] <= fire && is_last;
      vld_pipe[2] <= vld_pipe[1];
      lst_pipe[2] <= lst_pipe[1];
    end
  end

  // psum side: sample on the edge ending a v2 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_fresh <= 1'b1;
    end else if (vld_pipe[2]) begin
      acc       <= acc_sum;
      acc_fresh <= lst_pipe[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < fifo_depth; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= acc_sum;
        wr_ptr      <= wr_ptr + pw'(1);
      end
      if (pop) rd_ptr <= rd_ptr + pw'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + cw'(1);
        2'b01:   fifo_count <= fifo_count - cw'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;
  localparam int BP = 19;
  localparam int BA = 23;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_accum_if #(.bw_psum(BP), .bw_acc(BA)) bus();
  psum_accum #(.bw_psum(BP), .bw_acc(BA), .fifo_depth(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_run = 0, n_fail = 0;
  longint exp_q[$];
  int iss_q[$];
  int vals[$];
  int acc_cnt = 0, pop_cnt = 0, done_cnt = 0;

  logic          fire = 1'b0;
  logic [BP-1:0] fire_val = '0, iss_val = '0, mac_p1 = '0, mac_p2 = '0;

  assign bus.psum = mac_p2;

  task automatic chk(input string tag, input longint got, input longint want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // MAC tile model: psum for an issue appears two edges after acceptance.
  always @(posedge clk) begin
    mac_p1 <= fire ? fire_val : '0;
    mac_p2 <= mac_p1;
  end

  // Issue driver: presents the head of iss_q until accepted.
  initial forever begin
    @(posedge clk); #1;
    bus.in_valid = (iss_q.size() != 0);
    if (iss_q.size() != 0) iss_val = BP'(iss_q[0]);
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    longint want;
    fire     = bus.in_valid && bus.in_ready;
    fire_val = iss_val;
    if (fire) begin
      void'(iss_q.pop_front());
      acc_cnt++;
    end
    if (!reset && bus.done) done_cnt++;
    if (!reset && bus.out_valid && bus.out_ready) begin
      pop_cnt++;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h7fff_ffff_ffff_ffff;
      chk("out_data", $signed(bus.out_data), want);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int l, input int g);
    bus.len = 4'(l); bus.ngroups = 8'(g); bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic issue_vals();
    foreach (vals[i]) iss_q.push_back(vals[i]);
  endtask

  // Reference: each group sum wrapped to BA bits and sign-extended.
  task automatic model_exp(input int l, input int g);
    for (int gi = 0; gi < g; gi++) begin
      longint s = 0;
      logic signed [BA-1:0] w;
      for (int k = 0; k < l; k++) s += vals[gi*l + k];
      w = BA'(s);
      exp_q.push_back(longint'(w));
    end
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    bus.out_ready = 1'b1;
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, a0, d0, k;
    reset = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.ngroups = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    reset = 1'b0;
    tick(1);

    // zero-field starts are ignored
    pulse_start(0, 3); tick(1);
    chk("len0_busy", bus.busy, 0);
    pulse_start(2, 0); tick(1);
    chk("ng0_busy", bus.busy, 0);

    // two groups of two; start while busy is ignored
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start(2, 2);
    chk("j1_busy", bus.busy, 1);
    vals.delete();
    vals.push_back(5); vals.push_back(-3); vals.push_back(100); vals.push_back(-1);
    issue_vals(); model_exp(2, 2);
    pulse_start(1, 1);
    tick(12);
    chk("j1_head", $signed(bus.out_data), 2);
    tick(3);
    chk("j1_head_hold", $signed(bus.out_data), 2);
    chk("j1_out_valid", bus.out_valid, 1);
    chk("j1_no_early_done", done_cnt - d0, 0);
    bus.out_ready = 1'b1;
    wait_done("j1", 100, 1'b0);
    chk("j1_pops", pop_cnt - p0, 2);
    chk("j1_idle", bus.busy, 0);

    // backpressure: only four results may be reserved
    bus.out_ready = 1'b0;
    p0 = pop_cnt; a0 = acc_cnt;
    pulse_start(1, 6);
    vals.delete();
    for (int i = 1; i <= 6; i++) vals.push_back(i * 11 - 40);
    issue_vals(); model_exp(1, 6);
    tick(20);
    chk("bp_accepted", acc_cnt - a0, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait_done("bp", 200, 1'b0);
    chk("bp_pops", pop_cnt - p0, 6);

    // extreme psums, len=15, checked against closed-form results
    pulse_start(15, 2);
    vals.delete();
    for (int i = 0; i < 15; i++) vals.push_back(-262144);
    for (int i = 0; i < 15; i++) vals.push_back(262143);
    issue_vals();
    exp_q.push_back(-64'sd3932160);
    exp_q.push_back(64'sd3932145);
    wait_done("ext", 300, 1'b0);

    // random psums with random consumer stalls
    pulse_start(3, 20);
    vals.delete();
    for (int i = 0; i < 60; i++) vals.push_back(int'($urandom_range(0, 524287)) - 262144);
    issue_vals(); model_exp(3, 20);
    wait_done("rnd3", 2000, 1'b1);
    pulse_start(1, 12);
    vals.delete();
    for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(0, 524287)) - 262144);
    issue_vals(); model_exp(1, 12);
    wait_done("rnd1", 2000, 1'b1);

    // reset mid-job, then a clean single-result job
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    pulse_start(2, 3);
    vals.delete();
    for (int i = 0; i < 6; i++) vals.push_back(1000 + i);
    issue_vals(); model_exp(2, 3);
    k = 0;
    while (acc_cnt - a0 < 3 && k < 50) begin tick(1); k++; end
    chk("mid_reached", acc_cnt - a0, 3);
    reset = 1'b1;
    iss_q.delete(); exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    p0 = pop_cnt;
    pulse_start(1, 1);
    vals.delete(); vals.push_back(7);
    issue_vals(); model_exp(1, 1);
    wait_done("post_rst", 100, 1'b0);
    tick(10);
    chk("post_rst_pops", pop_cnt - p0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameter: bw_psum, 19, width of the psum input from the MAC tile.
REQ-002 Parameter: bw_acc, 23, accumulator and result width (bw_psum+4, holds 16 psums without overflow).
REQ-003 Parameter: fifo_depth, 4, number of result FIFO entries (power of 2).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle pulse that latches len and ngroups; ignored while busy=1.
REQ-007 Port: len  in  4  number of psums per result (1..15).
REQ-008 Port: ngroups  in  8  number of results per job (1..255).
REQ-009 Port: in_valid  in  1  an issue is presented to the MAC tile this cycle.
REQ-010 Port: in_ready  out  1  the issue is accepted; an issue counts only when in_valid=1 and in_ready=1.
REQ-011 Port: psum  in  bw_psum  signed MAC tile output, valid 2 edges after the accepted issue.
REQ-012 Port: out_data  out  bw_acc  signed result at the FIFO head.
REQ-013 Port: out_valid  out  1  FIFO non-empty.
REQ-014 Port: out_ready  in  1  consumer pops the head when out_valid=1 and out_ready=1.
REQ-015 Port: busy  out  1  high when state is not IDLE.
REQ-016 Port: done  out  1  one-cycle pulse on the DRAIN->IDLE transition.

Function
REQ-017 FSM states SHALL be IDLE, ACC and DRAIN.
REQ-018 In IDLE, a start with len!=0 and ngroups!=0 SHALL latch both values and enter ACC; a start with a zero field SHALL be ignored.
REQ-019 In ACC, the block SHALL count accepted issues and enter DRAIN on the edge that accepts issue number len*ngroups.
REQ-020 In DRAIN, in_ready SHALL be 0; the block SHALL go to IDLE when the valid pipe is empty and the FIFO is empty, and pulse done in the same cycle.
REQ-021 An accepted issue SHALL enter a 2-stage valid pipe (v1, v2); psum SHALL be sampled on the edge that ends the cycle in which v2=1.
REQ-022 A sampled psum SHALL be sign-extended to bw_acc bits.
REQ-023 The first psum of a group SHALL load acc with psum; this requires no clear cycle.
REQ-024 Each later psum SHALL add psum to acc, modulo 2^bw_acc.
REQ-025 On the len-th psum of a group, the value acc+psum (or psum alone when len=1) SHALL be pushed into the FIFO on the same edge, and the group counter SHALL restart.
REQ-026 A last-of-group flag SHALL travel down the pipe with v1/v2; the group position SHALL be decided at issue time, not at psum time.
REQ-027 in_ready SHALL be 1 only in ACC, and only when fifo_count + pending < fifo_depth, where pending is the number of last-of-group issues still in v1/v2 (0..2).
REQ-028 Because of REQ-027, the FIFO SHALL never overflow; a push and a pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-029 out_data SHALL show the head entry combinationally, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 A pop while empty SHALL have no effect.
REQ-031 The issue counter SHALL wrap only at job end, and the FIFO pointers SHALL wrap modulo fifo_depth.

Reset
REQ-032 reset SHALL force IDLE and clear acc, all counters, v1/v2 and the FIFO; busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
REQ-033 Reset asserted mid-job SHALL discard in-flight psums and queued results; the next start SHALL behave as after power-up.

Verification
REQ-034 start(len=2, ngroups=2), psums 5,-3,100,-1 on successive cycles -> FIFO holds 2 then 99; done pulses after both are popped.
REQ-035 len=1, ngroups=6, out_ready=0 -> in_ready drops after 4 accepted issues; exactly 4 entries are queued and no data is lost; raising out_ready completes all 6.
REQ-036 len=15, all psums = -2^18 -> result -15*2^18 with no wrap; len=15 with psum = 2^18-1 -> result 15*(2^18-1).
REQ-037 A push on the same edge as a pop at count=3 -> count stays 3 and output order is preserved.
REQ-038 reset asserted during group 2 of 3, then start(len=1, ngroups=1) with psum 7 -> exactly one result, 7; no stale data appears.
REQ-039 start with len=0, and start while busy -> both are ignored; state and counters are unchanged.
